// File: rtl/hamming_pkg.sv
// Shared types and width helpers for the Hamming frame accumulator.
package hamming_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MODE_SIM  = 0;
  localparam int unsigned MODE_DIST = 1;

  // Bits needed to hold the per-beat count (0..width).
  function automatic int unsigned beat_width(int unsigned width);
    return $clog2(width + 1);
  endfunction

  // Bits needed for a frame total; exact, so the accumulator cannot wrap.
  function automatic int unsigned count_width(int unsigned width, int unsigned max_words);
    return $clog2(width * max_words + 1);
  endfunction

  function automatic int unsigned words_width(int unsigned max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/hamming_popcount.sv
// Combinational per-beat count of agreeing (MODE_SIM) or differing (MODE_DIST) bit positions.
module hamming_popcount import hamming_pkg::*; #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MODE  = MODE_SIM,
  localparam int unsigned BW   = beat_width(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [BW-1:0]    cnt_o
);

  logic [WIDTH-1:0] hit;

  always_comb begin
    hit   = (MODE == MODE_DIST) ? (a_i ^ b_i) : ~(a_i ^ b_i);
    cnt_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_o = cnt_o + BW'(hit[i]);
    end
  end

endmodule

// File: rtl/hamming_frame_acc.sv
// Streaming Hamming comparator accumulating per-beat counts over a frame ended by in_last.
// Define HAMMING_THRESH_EN to add the registered thresh_hit output (count >= THRESH).
module hamming_frame_acc import hamming_pkg::*; #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_WORDS = 16,
  parameter int unsigned MODE      = MODE_SIM,
  parameter int unsigned THRESH    = 4,
  localparam int unsigned CW       = count_width(WIDTH, MAX_WORDS),
  localparam int unsigned WW       = words_width(MAX_WORDS),
  localparam int unsigned BW       = beat_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_last_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CW-1:0]    count_o,
  output logic [WW-1:0]    words_o,
`ifdef HAMMING_THRESH_EN
  output logic             thresh_hit_o,
`endif
  output logic             ovf_o
);

  state_e        state_q, state_d;
  logic          ready_q;
  logic [BW-1:0] beat_cnt;
  logic          accept, frame_end;

  logic [CW-1:0] acc_q, acc_d, count_q;
  logic [WW-1:0] words_q, words_d, wout_q;
  logic          ovf_acc_q, ovf_acc_d, ovf_q;

  hamming_popcount #(
    .WIDTH (WIDTH),
    .MODE  (MODE)
  ) u_popcount (
    .a_i   (a_i),
    .b_i   (b_i),
    .cnt_o (beat_cnt)
  );

  // ready is a register so it reads 0 while reset is held and 1 from the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = in_last_i ? DONE : ACC;
      ACC:     if (accept && in_last_i) state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = ready_q;
    out_valid_o = (state_q == DONE);
    accept      = in_valid_i && ready_q;
    frame_end   = accept && in_last_i;
  end

  // Beats past MAX_WORDS are absorbed but only flag overflow.
  always_comb begin
    acc_d     = acc_q;
    words_d   = words_q;
    ovf_acc_d = ovf_acc_q;
    if (accept) begin
      if (state_q == IDLE) begin
        acc_d     = CW'(beat_cnt);
        words_d   = WW'(1);
        ovf_acc_d = 1'b0;
      end else if (words_q < WW'(MAX_WORDS)) begin
        acc_d   = acc_q + CW'(beat_cnt);
        words_d = words_q + WW'(1);
      end else begin
        ovf_acc_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      words_q   <= '0;
      ovf_acc_q <= 1'b0;
      count_q   <= '0;
      wout_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      words_q   <= words_d;
      ovf_acc_q <= ovf_acc_d;
      if (frame_end) begin
        count_q <= acc_d;
        wout_q  <= words_d;
        ovf_q   <= ovf_acc_d;
      end
    end
  end

  assign count_o = count_q;
  assign words_o = wout_q;
  assign ovf_o   = ovf_q;

`ifdef HAMMING_THRESH_EN
  logic thresh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_q <= 1'b0;
    end else if (frame_end) begin
      thresh_q <= (32'(acc_d) >= THRESH);
    end
  end

  assign thresh_hit_o = thresh_q;
`endif

endmodule

// File: tb/tb_hamming_frame_acc.sv
// Bench for hamming_frame_acc: MODE=0 and MODE=1 instances share stimulus; popcount swept apart.
module tb_hamming_frame_acc;
  import hamming_pkg::*;

  localparam int unsigned MAXW = 4;
  localparam int unsigned THR  = 6;

  logic       clk, rst_n;
  logic       in_valid, in_last, out_ready;
  logic [7:0] a_in, b_in;
  logic       in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
  logic [5:0] count0, count1;
  logic [2:0] words0, words1;
`ifdef HAMMING_THRESH_EN
  logic       thr0, thr1;
`endif

  logic [7:0] pa, pb;
  logic [3:0] pc_sim, pc_dist;

  int nvec  = 0;
  int nfail = 0;

  hamming_frame_acc #(.WIDTH(8), .MAX_WORDS(MAXW), .MODE(MODE_SIM), .THRESH(THR)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .in_last_i(in_last), .a_i(a_in), .b_i(b_in), .out_valid_o(out_valid0),
    .out_ready_i(out_ready), .count_o(count0), .words_o(words0),
`ifdef HAMMING_THRESH_EN
    .thresh_hit_o(thr0),
`endif
    .ovf_o(ovf0)
  );

  hamming_frame_acc #(.WIDTH(8), .MAX_WORDS(MAXW), .MODE(MODE_DIST), .THRESH(THR)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .in_last_i(in_last), .a_i(a_in), .b_i(b_in), .out_valid_o(out_valid1),
    .out_ready_i(out_ready), .count_o(count1), .words_o(words1),
`ifdef HAMMING_THRESH_EN
    .thresh_hit_o(thr1),
`endif
    .ovf_o(ovf1)
  );

  hamming_popcount #(.WIDTH(8), .MODE(MODE_SIM))  u_pc_sim  (.a_i(pa), .b_i(pb), .cnt_o(pc_sim));
  hamming_popcount #(.WIDTH(8), .MODE(MODE_DIST)) u_pc_dist (.a_i(pa), .b_i(pb), .cnt_o(pc_dist));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [2:0]      n;
    logic [5:0][7:0] a;
    logic [5:0][7:0] b;
    logic [5:0]      c0;
    logic [5:0]      c1;
    logic [2:0]      w;
    logic            ovf;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] fa[8];
  logic [7:0] fb[8];

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference: sum of bit agreements/differences over the first MAXW beats.
  function automatic int beat_val(input logic [7:0] a, input logic [7:0] b, input int mode);
    return (mode == 1) ? $countones(a ^ b) : 8 - $countones(a ^ b);
  endfunction

  task automatic model(input int n, output int c0, output int c1, output int w, output int ov);
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < n && k < MAXW; k++) begin
      c0 += beat_val(fa[k], fb[k], 0);
      c1 += beat_val(fa[k], fb[k], 1);
    end
    w  = (n < MAXW) ? n : MAXW;
    ov = (n > MAXW) ? 1 : 0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    a_in     = 8'($urandom);
    b_in     = 8'($urandom);
    in_last  = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    in_last  = last;
    while (!in_ready0 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready0) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in     = 8'($urandom);
    b_in     = 8'($urandom);
  endtask

  task automatic check_out(input string tag, input int c0, input int c1, input int w,
                           input int ov);
    check({tag, ".valid0"}, int'(out_valid0), 1);
    check({tag, ".valid1"}, int'(out_valid1), 1);
    check({tag, ".ready0"}, int'(in_ready0), 0);
    check({tag, ".count0"}, int'(count0), c0);
    check({tag, ".count1"}, int'(count1), c1);
    check({tag, ".words0"}, int'(words0), w);
    check({tag, ".words1"}, int'(words1), w);
    check({tag, ".ovf0"}, int'(ovf0), ov);
    check({tag, ".ovf1"}, int'(ovf1), ov);
`ifdef HAMMING_THRESH_EN
    check({tag, ".thr0"}, int'(thr0), (c0 >= THR) ? 1 : 0);
    check({tag, ".thr1"}, int'(thr1), (c1 >= THR) ? 1 : 0);
`endif
  endtask

  task automatic handshake(input string tag, input int c0, input int c1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".drop_valid"}, int'(out_valid0), 0);
    check({tag, ".hold_count0"}, int'(count0), c0);
    check({tag, ".hold_count1"}, int'(count1), c1);
    check({tag, ".ready_back"}, int'(in_ready0), 1);
  endtask

  // Sends fa/fb[0..n-1]; result must be visible right after the edge that took the last beat.
  task automatic run_frame(input string tag, input int n, input int c0, input int c1,
                           input int w, input int ov, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) idle_cycle();
      send_beat(fa[k], fb[k], (k == n - 1));
    end
    check_out(tag, c0, c1, w, ov);
  endtask

  initial begin
    int c0, c1, w, ov, n, e0, e1;

    for (int v = 0; v < 6; v++) vecs[v] = '0;
    vecs[0].n = 1; vecs[0].a[0] = 8'hFF; vecs[0].b[0] = 8'hFF;
    vecs[0].c0 = 8; vecs[0].c1 = 0; vecs[0].w = 1; vecs[0].ovf = 0;
    vecs[1].n = 4;
    vecs[1].a[0] = 8'hA5; vecs[1].b[0] = 8'h5A; vecs[1].a[1] = 8'hF0; vecs[1].b[1] = 8'hF0;
    vecs[1].a[2] = 8'h0F; vecs[1].b[2] = 8'h00; vecs[1].a[3] = 8'h01; vecs[1].b[3] = 8'h00;
    vecs[1].c0 = 19; vecs[1].c1 = 13; vecs[1].w = 4; vecs[1].ovf = 0;
    vecs[2].n = 6;
    for (int k = 0; k < 6; k++) begin
      vecs[2].a[k] = 8'hFF;
      vecs[2].b[k] = 8'hFF;
    end
    vecs[2].c0 = 32; vecs[2].c1 = 0; vecs[2].w = 4; vecs[2].ovf = 1;
    vecs[3].n = 1; vecs[3].a[0] = 8'hA5; vecs[3].b[0] = 8'h5A;
    vecs[3].c0 = 0; vecs[3].c1 = 8; vecs[3].w = 1; vecs[3].ovf = 0;
    vecs[4].n = 1; vecs[4].a[0] = 8'h3C; vecs[4].b[0] = 8'h3C;
    vecs[4].c0 = 8; vecs[4].c1 = 0; vecs[4].w = 1; vecs[4].ovf = 0;
    vecs[5].n = 5;
    for (int k = 0; k < 4; k++) begin
      vecs[5].a[k] = 8'h00;
      vecs[5].b[k] = 8'hFF;
    end
    vecs[5].a[4] = 8'hFF; vecs[5].b[4] = 8'h00;
    vecs[5].c0 = 0; vecs[5].c1 = 32; vecs[5].w = 4; vecs[5].ovf = 1;

    // Reset state
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    a_in      = 8'h00;
    b_in      = 8'h00;
    pa        = 8'h00;
    pb        = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready0", int'(in_ready0), 0);
    check("rst.valid0", int'(out_valid0), 0);
    check("rst.count0", int'(count0), 0);
    check("rst.words0", int'(words0), 0);
    check("rst.ovf0", int'(ovf0), 0);
`ifdef HAMMING_THRESH_EN
    check("rst.thr0", int'(thr0), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst.ready0", int'(in_ready0), 1);
    check("post_rst.ready1", int'(in_ready1), 1);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 6; k++) begin
        fa[k] = vecs[v].a[k];
        fb[k] = vecs[v].b[k];
      end
      run_frame($sformatf("tbl%0d", v), int'(vecs[v].n), int'(vecs[v].c0), int'(vecs[v].c1),
                int'(vecs[v].w), int'(vecs[v].ovf), 1'b0);
      handshake($sformatf("tbl%0d", v), int'(vecs[v].c0), int'(vecs[v].c1));
    end

    // Back-pressure in DONE with in_valid asserted: nothing may be absorbed.
    fa[0] = 8'hF0; fb[0] = 8'h0F;
    run_frame("bp", 1, 0, 8, 1, 0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      a_in     = 8'($urandom);
      b_in     = 8'($urandom);
      @(posedge clk);
      #1;
      check_out($sformatf("bp_hold%0d", c), 0, 8, 1, 0);
    end
    in_valid = 1'b0;
    handshake("bp", 0, 8);
    repeat (3) idle_cycle();
    check("idle.valid0", int'(out_valid0), 0);
    check("idle.count1", int'(count1), 8);
    fa[0] = 8'h00; fb[0] = 8'hFF;
    run_frame("bp_next", 1, 0, 8, 1, 0, 1'b0);
    handshake("bp_next", 0, 8);

    // Reset mid-frame discards the partial frame and clears outputs at once.
    send_beat(8'hFF, 8'hFF, 1'b0);
    send_beat(8'hFF, 8'hFF, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst.count1", int'(count1), 0);
    check("midrst.words0", int'(words0), 0);
    check("midrst.valid0", int'(out_valid0), 0);
    check("midrst.ready0", int'(in_ready0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fa[0] = 8'h00; fb[0] = 8'h00;
    run_frame("midrst_next", 1, 8, 0, 1, 0, 1'b0);
    handshake("midrst_next", 8, 0);

    // Randomized frames against the reference model.
    for (int f = 0; f < 60; f++) begin
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++) begin
        fa[k] = 8'($urandom);
        fb[k] = 8'($urandom);
      end
      model(n, c0, c1, w, ov);
      run_frame($sformatf("rnd%0d", f), n, c0, c1, w, ov, 1'b1);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
        check($sformatf("rnd%0d.wait_valid", f), int'(out_valid1), 1);
      end
      handshake($sformatf("rnd%0d", f), c0, c1);
    end

    // Exhaustive single-beat popcount sweep.
    for (int i = 0; i < 65536; i++) begin
      pa = i[15:8];
      pb = i[7:0];
      #1;
      e0 = beat_val(pa, pb, 0);
      e1 = beat_val(pa, pb, 1);
      check("sweep_sim", int'(pc_sim), e0);
      check("sweep_dist", int'(pc_dist), e1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
